crc_word_sequencer: RTL and testbench

- Upstream driver for the 5-bit HDR-DDR CRC engine in the target datapath.
- Accepts 16-bit DDR data words from the frame deserializer/serializer and splits each word into two bytes, MSB byte first.
- Drives the engine's byte handshake: a 1-cycle data_valid strobe, then 8 idle shift cycles per byte.
- Closes the frame with a last_byte strobe, captures the resulting CRC and, in receive mode, compares it against the received CRC word and flags an error.

---
 rtl/crc_word_sequencer_if.sv | 38 +++
 rtl/crc_word_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_crc_word_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_word_sequencer_if.sv
// Word-side, rx-CRC, engine-side and frame-status signals of crc_word_sequencer.
// The slave modport is the sequencer itself; master is whatever drives it.
interface crc_word_sequencer_if;
   logic        i_seq_en;
   logic        i_word_valid;
   logic [15:0] i_word;
   logic        i_word_last;
   logic        o_word_ready;
   logic        i_chk_mode;
   logic [4:0]  i_rx_crc;
   logic        i_rx_crc_valid;
   logic        o_crc_en;
   logic        o_crc_data_valid;
   logic        o_crc_last_byte;
   logic [7:0]  o_crc_data;
   logic [4:0]  i_crc_value;
   logic        i_crc_valid;
   logic [4:0]  o_frame_crc;
   logic        o_frame_done;
   logic        o_crc_error;
   logic        o_busy;

   // Word handshake: a word transfers on a rising edge where i_word_valid and
   // o_word_ready are both high; the driver holds i_word/i_word_last while not ready.
   modport slave (
      input  i_seq_en, i_word_valid, i_word, i_word_last, i_chk_mode,
             i_rx_crc, i_rx_crc_valid, i_crc_value, i_crc_valid,
      output o_word_ready, o_crc_en, o_crc_data_valid, o_crc_last_byte,
             o_crc_data, o_frame_crc, o_frame_done, o_crc_error, o_busy
   );

   modport master (
      output i_seq_en, i_word_valid, i_word, i_word_last, i_chk_mode,
             i_rx_crc, i_rx_crc_valid, i_crc_value, i_crc_valid,
      input  o_word_ready, o_crc_en, o_crc_data_valid, o_crc_last_byte,
             o_crc_data, o_frame_crc, o_frame_done, o_crc_error, o_busy
   );
endinterface

// File: rtl/crc_word_sequencer.sv
// Feeds 16-bit words into the 5-bit HDR-DDR CRC engine one byte at a time (MSB
// byte first), closes the frame, captures the CRC and optionally checks it.
module crc_word_sequencer #(
   parameter int SHIFT_CYCLES = 8,
   parameter int CRC_TIMEOUT  = 4
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   crc_word_sequencer_if.slave   bus,
   output logic [3:0]            o_dbg_state
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      LOAD_HI  = 4'd1,
      SHIFT_HI = 4'd2,
      LOAD_LO  = 4'd3,
      SHIFT_LO = 4'd4,
      LAST     = 4'd5,
      WAIT_CRC = 4'd6,
      CHECK    = 4'd7,
      DONE     = 4'd8,
      ABORT    = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] word_q, word_d;
   logic        last_q, last_d;
   logic        frame_open_q, frame_open_d;
   logic        mode_q, mode_d;
   logic [4:0]  rx_crc_q, rx_crc_d;
   logic        rx_lat_q, rx_lat_d;
   logic [7:0]  byte_q, byte_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  tmo_q, tmo_d;
   logic [4:0]  frame_crc_q, frame_crc_d;
   logic        err_q, err_d;

   logic        ready_c, dv_c, lb_c, done_c, abort_c;

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state_q      <= IDLE;
         word_q       <= '0;
         last_q       <= 1'b0;
         frame_open_q <= 1'b0;
         mode_q       <= 1'b0;
         rx_crc_q     <= '0;
         rx_lat_q     <= 1'b0;
         byte_q       <= '0;
         cnt_q        <= '0;
         tmo_q        <= '0;
         frame_crc_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         last_q       <= last_d;
         frame_open_q <= frame_open_d;
         mode_q       <= mode_d;
         rx_crc_q     <= rx_crc_d;
         rx_lat_q     <= rx_lat_d;
         byte_q       <= byte_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         frame_crc_q  <= frame_crc_d;
         err_q        <= err_d;
      end
   end

   // An enable drop only aborts once a frame has something in flight.
   assign abort_c = !bus.i_seq_en &&
                    ((state_q inside {LOAD_HI, SHIFT_HI, LOAD_LO, SHIFT_LO,
                                      LAST, WAIT_CRC, CHECK}) ||
                     (state_q == IDLE && frame_open_q));

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      last_d       = last_q;
      frame_open_d = frame_open_q;
      mode_d       = mode_q;
      rx_crc_d     = rx_crc_q;
      rx_lat_d     = rx_lat_q;
      byte_d       = byte_q;
      cnt_d        = cnt_q;
      tmo_d        = tmo_q;
      frame_crc_d  = frame_crc_q;
      err_d        = err_q;
      ready_c      = 1'b0;
      dv_c         = 1'b0;
      lb_c         = 1'b0;
      done_c       = 1'b0;

      // Rx CRC may arrive before the first word; the latest strobe wins.
      if (bus.i_rx_crc_valid && (frame_open_q || state_q == IDLE)) begin
         rx_crc_d = bus.i_rx_crc;
         rx_lat_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            ready_c = bus.i_seq_en;
            if (bus.i_seq_en && bus.i_word_valid) begin
               word_d       = bus.i_word;
               last_d       = bus.i_word_last;
               byte_d       = bus.i_word[15:8];
               frame_open_d = 1'b1;
               if (!frame_open_q) mode_d = bus.i_chk_mode;
               state_d      = LOAD_HI;
            end
         end
         LOAD_HI: begin
            dv_c    = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (cnt_q == 4'(SHIFT_CYCLES - 1)) begin
               cnt_d   = '0;
               byte_d  = word_q[7:0];
               state_d = LOAD_LO;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         LOAD_LO: begin
            dv_c    = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (cnt_q == 4'(SHIFT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = last_q ? LAST : IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         LAST: begin
            lb_c    = 1'b1;
            tmo_d   = '0;
            state_d = WAIT_CRC;
         end
         WAIT_CRC: begin
            if (bus.i_crc_valid) begin
               frame_crc_d = bus.i_crc_value;
               state_d     = CHECK;
            end else if (tmo_q == 4'(CRC_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 4'd1;
            end
         end
         CHECK: begin
            // Receive mode waits here indefinitely for the far-end CRC.
            if (!mode_q) begin
               err_d   = 1'b0;
               state_d = DONE;
            end else if (bus.i_rx_crc_valid) begin
               err_d   = (bus.i_rx_crc != frame_crc_q);
               state_d = DONE;
            end else if (rx_lat_q) begin
               err_d   = (rx_crc_q != frame_crc_q);
               state_d = DONE;
            end
         end
         DONE: begin
            done_c       = 1'b1;
            frame_open_d = 1'b0;
            rx_lat_d     = 1'b0;
            rx_crc_d     = '0;
            state_d      = IDLE;
         end
         ABORT: begin
            lb_c         = 1'b1;
            frame_open_d = 1'b0;
            rx_lat_d     = 1'b0;
            rx_crc_d     = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort_c) begin
         state_d     = ABORT;
         cnt_d       = '0;
         frame_crc_d = frame_crc_q;
         err_d       = err_q;
      end
   end

   assign bus.o_word_ready     = ready_c;
   assign bus.o_crc_data_valid = dv_c;
   assign bus.o_crc_last_byte  = lb_c;
   assign bus.o_crc_data       = byte_q;
   assign bus.o_crc_en         = frame_open_q || (state_q == ABORT);
   assign bus.o_frame_crc      = frame_crc_q;
   assign bus.o_frame_done     = done_c;
   assign bus.o_crc_error      = done_c && err_q;
   assign bus.o_busy           = (state_q != IDLE) || frame_open_q;
   assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_crc_word_sequencer.sv
// Bench for crc_word_sequencer: table of directed frames, hand-written abort and
// reset sequences, then random frames checked against a timing/CRC rule model.
module tb_crc_word_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   crc_word_sequencer_if bus ();
   logic [3:0] dbg_state;

   crc_word_sequencer #(.SHIFT_CYCLES(8), .CRC_TIMEOUT(4)) dut (
      .i_sys_clk   (clk),
      .i_sys_rst   (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   typedef struct {
      logic [15:0] w0, w1, w2;
      int          n;
      bit          mode;
      logic [4:0]  ev;
      int          ed;     // engine response delay after last_byte, 0 = never
      logic [4:0]  rv;
      int          roff;   // rx strobe cycle relative to first word presented
      logic [4:0]  xcrc;
      bit          xerr;
      int          xdone;  // done cycle relative to first word acceptance
   } vec_t;

   vec_t tbl[8];
   int   vec_cnt = 0;
   int   err_cnt = 0;
   logic [4:0] model_crc = '0;

   // scoreboard
   logic [7:0] exp_q[$];
   int         dv_cyc_q[$];
   int         lb_cnt = 0, lb_cyc = 0, done_cnt = 0, done_cyc = 0;
   logic [4:0] done_crc;
   logic       done_err;

   // engine stub
   int         eng_delay = 1;
   logic [4:0] eng_val = '0;
   int         eng_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      bus.i_crc_valid = 1'b0;
      if (!rst_n) begin
         eng_cnt = 0;
      end else begin
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus.i_crc_valid = 1'b1;
               bus.i_crc_value = eng_val;
            end
         end
         if (bus.o_crc_last_byte && eng_delay > 0) eng_cnt = eng_delay;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_crc_data_valid || bus.o_crc_last_byte)
            check("dv_lb_exclusive", 32'(bus.o_crc_data_valid & bus.o_crc_last_byte), 0);
         if (bus.o_crc_data_valid) begin
            dv_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL unexpected_byte: got %0h expected none", bus.o_crc_data);
            end else begin
               check("byte", 32'(bus.o_crc_data), 32'(exp_q.pop_front()));
            end
         end
         if (bus.o_crc_last_byte) begin
            lb_cnt++;
            lb_cyc = cyc;
         end
         if (bus.o_frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_crc = bus.o_frame_crc;
            done_err = bus.o_crc_error;
         end
      end
   end

   // Expected outcome from the frame rules: 19 cycles per word, last_byte after
   // the final byte, engine reply or timeout, then tx/rx completion.
   function automatic vec_t model_exp(input vec_t v);
      vec_t r = v;
      int last = 19 * v.n;
      int chk;
      if (v.ed == 0) begin
         r.xdone = last + 5;
         r.xerr  = 1'b1;
         r.xcrc  = model_crc;
      end else begin
         chk    = last + v.ed + 1;
         r.xcrc = v.ev;
         if (!v.mode) begin
            r.xdone = chk + 1;
            r.xerr  = 1'b0;
         end else begin
            r.xdone = ((v.roff > chk) ? v.roff : chk) + 1;
            r.xerr  = (v.rv != v.ev);
         end
      end
      return r;
   endfunction

   task automatic run_frame(input vec_t v, input string tag);
      logic [15:0] ww[3];
      int s, lb0, d0, t;
      ww[0] = v.w0; ww[1] = v.w1; ww[2] = v.w2;
      lb0 = lb_cnt;
      d0  = done_cnt;
      eng_val   = v.ev;
      eng_delay = v.ed;
      dv_cyc_q.delete();
      for (int i = 0; i < v.n; i++) begin
         exp_q.push_back(ww[i][15:8]);
         exp_q.push_back(ww[i][7:0]);
      end
      bus.i_chk_mode = v.mode;
      s = cyc;
      fork
         begin : drv
            for (int i = 0; i < v.n; i++) begin
               int waited = 0;
               bus.i_word_valid = 1'b1;
               bus.i_word       = ww[i];
               bus.i_word_last  = (i == v.n - 1);
               while (!bus.o_word_ready && waited < 60) begin
                  tick();
                  waited++;
               end
               check($sformatf("%s_accept%0d", tag, i), 32'(cyc - s), 32'(19 * i));
               tick();
            end
            bus.i_word_valid = 1'b0;
            bus.i_word_last  = 1'b0;
         end
         begin : rx
            if (v.mode) begin
               repeat (v.roff) tick();
               bus.i_rx_crc       = v.rv;
               bus.i_rx_crc_valid = 1'b1;
               tick();
               bus.i_rx_crc_valid = 1'b0;
            end
         end
      join
      t = 0;
      while (done_cnt == d0 && t < 200) begin
         tick();
         t++;
      end
      check({tag, "_done_count"}, 32'(done_cnt - d0), 1);
      check({tag, "_done_cycle"}, 32'(done_cyc - s), 32'(v.xdone));
      check({tag, "_frame_crc"}, 32'(done_crc), 32'(v.xcrc));
      check({tag, "_crc_error"}, 32'(done_err), 32'(v.xerr));
      check({tag, "_last_byte_count"}, 32'(lb_cnt - lb0), 1);
      check({tag, "_last_byte_cycle"}, 32'(lb_cyc - s), 32'(19 * v.n));
      check({tag, "_byte_count"}, 32'(dv_cyc_q.size()), 32'(2 * v.n));
      for (int i = 0; i < 2 * v.n && i < dv_cyc_q.size(); i++)
         check($sformatf("%s_dv_cycle%0d", tag, i), 32'(dv_cyc_q[i] - s),
               32'(19 * (i / 2) + ((i % 2) ? 10 : 1)));
      check({tag, "_bytes_left"}, 32'(exp_q.size()), 0);
      model_crc = v.xcrc;
      tick();
      tick();
   endtask

   task automatic rand_frame(input string tag);
      vec_t v;
      int last;
      v.n    = $urandom_range(1, 3);
      v.w0   = 16'($urandom);
      v.w1   = 16'($urandom);
      v.w2   = 16'($urandom);
      v.mode = 1'($urandom_range(0, 1));
      v.ev   = 5'($urandom);
      v.ed   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 4);
      v.rv   = ($urandom_range(0, 1) == 1) ? v.ev : 5'($urandom);
      last   = 19 * v.n;
      v.roff = (v.ed == 0) ? $urandom_range(0, last) : $urandom_range(0, last + v.ed + 6);
      v = model_exp(v);
      run_frame(v, tag);
   endtask

   task automatic abort_test();
      int s, lb0, d0;
      logic [4:0] crc0;
      lb0  = lb_cnt;
      d0   = done_cnt;
      crc0 = bus.o_frame_crc;
      eng_delay = 1;
      eng_val   = 5'h15;
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'h7E);
      bus.i_chk_mode   = 1'b0;
      bus.i_word_valid = 1'b1;
      bus.i_word       = 16'hC3A1;
      bus.i_word_last  = 1'b0;
      s = cyc;
      tick();
      bus.i_word = 16'h7E42;
      while (cyc < s + 19) tick();
      check("abort_second_ready", 32'(bus.o_word_ready), 1);
      tick();
      bus.i_word_valid = 1'b0;
      while (cyc < s + 23) tick();
      bus.i_seq_en = 1'b0;
      tick();
      check("abort_last_byte", 32'(bus.o_crc_last_byte), 1);
      check("abort_crc_en", 32'(bus.o_crc_en), 1);
      tick();
      check("abort_busy_after", 32'(bus.o_busy), 0);
      check("abort_crc_en_after", 32'(bus.o_crc_en), 0);
      while (cyc < s + 30) tick();
      check("abort_last_byte_count", 32'(lb_cnt - lb0), 1);
      check("abort_no_done", 32'(done_cnt - d0), 0);
      check("abort_crc_held", 32'(bus.o_frame_crc), 32'(crc0));
      check("abort_bytes_left", 32'(exp_q.size()), 0);
      bus.i_seq_en = 1'b1;
      tick();
   endtask

   task automatic async_reset_test();
      int s, d0;
      vec_t v;
      d0 = done_cnt;
      exp_q.push_back(8'hBE);
      eng_delay = 1;
      bus.i_chk_mode   = 1'b0;
      bus.i_word_valid = 1'b1;
      bus.i_word       = 16'hBEEF;
      bus.i_word_last  = 1'b1;
      s = cyc;
      tick();
      bus.i_word_valid = 1'b0;
      while (cyc < s + 5) tick();
      check("rst_busy_before", 32'(bus.o_busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(bus.o_busy), 0);
      check("rst_crc_en", 32'(bus.o_crc_en), 0);
      check("rst_crc_data", 32'(bus.o_crc_data), 0);
      check("rst_frame_crc", 32'(bus.o_frame_crc), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      model_crc = '0;
      repeat (25) tick();
      check("rst_no_done", 32'(done_cnt - d0), 0);
      check("rst_bytes_left", 32'(exp_q.size()), 0);
      v = '{16'h0F5A, 16'h0, 16'h0, 1, 1'b1, 5'h09, 1, 5'h08, 4, 5'h0, 1'b0, 0};
      v = model_exp(v);
      run_frame(v, "post_reset");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //          w0        w1        w2     n mode  ev    ed rv    roff xcrc  xerr xdone
      tbl[0] = '{16'hA55A, 16'h0000, 16'h0000, 1, 1'b0, 5'h0B, 1, 5'h00, 0,  5'h0B, 1'b0, 22};
      tbl[1] = '{16'h1234, 16'h5678, 16'h9ABC, 3, 1'b0, 5'h15, 2, 5'h00, 0,  5'h15, 1'b0, 61};
      tbl[2] = '{16'h1234, 16'hABCD, 16'h0000, 2, 1'b1, 5'h0B, 1, 5'h0B, 25, 5'h0B, 1'b0, 41};
      tbl[3] = '{16'h1234, 16'hABCD, 16'h0000, 2, 1'b1, 5'h0A, 1, 5'h0B, 25, 5'h0A, 1'b1, 41};
      tbl[4] = '{16'hA55A, 16'h0000, 16'h0000, 1, 1'b1, 5'h0B, 1, 5'h0B, 25, 5'h0B, 1'b0, 26};
      tbl[5] = '{16'h0F0F, 16'h0000, 16'h0000, 1, 1'b1, 5'h11, 0, 5'h03, 3,  5'h0B, 1'b1, 24};
      tbl[6] = '{16'h55AA, 16'h0000, 16'h0000, 1, 1'b1, 5'h1F, 3, 5'h1F, 0,  5'h1F, 1'b0, 24};
      tbl[7] = '{16'hFFFF, 16'h0001, 16'h0000, 2, 1'b0, 5'h04, 0, 5'h00, 0,  5'h1F, 1'b1, 43};

      bus.i_seq_en       = 1'b0;
      bus.i_word_valid   = 1'b0;
      bus.i_word         = '0;
      bus.i_word_last    = 1'b0;
      bus.i_chk_mode     = 1'b0;
      bus.i_rx_crc       = '0;
      bus.i_rx_crc_valid = 1'b0;
      bus.i_crc_value    = '0;
      bus.i_crc_valid    = 1'b0;

      tick();
      tick();
      check("reset_word_ready", 32'(bus.o_word_ready), 0);
      check("reset_crc_en", 32'(bus.o_crc_en), 0);
      check("reset_data_valid", 32'(bus.o_crc_data_valid), 0);
      check("reset_last_byte", 32'(bus.o_crc_last_byte), 0);
      check("reset_crc_data", 32'(bus.o_crc_data), 0);
      check("reset_frame_crc", 32'(bus.o_frame_crc), 0);
      check("reset_frame_done", 32'(bus.o_frame_done), 0);
      check("reset_crc_error", 32'(bus.o_crc_error), 0);
      check("reset_busy", 32'(bus.o_busy), 0);

      rst_n = 1'b1;
      bus.i_seq_en = 1'b1;
      tick();
      check("idle_ready", 32'(bus.o_word_ready), 1);
      tick();

      for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

      abort_test();
      rand_frame("after_abort");

      for (int i = 0; i < 20; i++) rand_frame($sformatf("rnd%0d", i));

      async_reset_test();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
